// File: rtl/sm_reg_dump_if.sv
`default_nettype none
// ============================================================================
// Module   : sm_reg_dump_if
// Brief    : Bundle for the register-dump engine: start/busy/done control, the
//            CPU debug read port and the valid/ready byte stream.
// Revision : 1.0 - initial release
// ============================================================================
interface sm_reg_dump_if;
    logic        start;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    // Dump engine side
    modport master (
        input  start,
        input  regData,
        input  tx_ready,
        output regAddr,
        output tx_data,
        output tx_valid,
        output busy,
        output done
    );

    // CPU debug port / serial transmitter / controller side
    modport slave (
        output start,
        output regData,
        output tx_ready,
        input  regAddr,
        input  tx_data,
        input  tx_valid,
        input  busy,
        input  done
    );
endinterface
`default_nettype wire

// File: rtl/sm_reg_dump.sv
`default_nettype none
// ============================================================================
// Module   : sm_reg_dump
// Brief    : Walks debug addresses 0..NREGS-1 and streams each 32-bit value as
//            big-endian bytes, framed by HEADER and a trailing XOR checksum.
// Revision : 1.0 - initial release
// ============================================================================
module sm_reg_dump #(
    parameter int unsigned NREGS  = 32,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  wire           clk,
    input  wire           rst,
    sm_reg_dump_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_SUM  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [4:0] c_last_addr = 5'(NREGS - 1);

    state_t      state_q,    state_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  tx_data_q,  tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic [7:0]  csum_q,     csum_d;
    logic [31:0] shreg_q,    shreg_d;
    logic [1:0]  cnt_q,      cnt_d;
    logic        w_hs;

    assign w_hs = tx_valid_q & bus.tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            reg_addr_q <= 5'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            csum_q     <= 8'd0;
            shreg_q    <= 32'd0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            reg_addr_q <= reg_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            csum_q     <= csum_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs are registered, so each transition loads the values the next
    // state must present on its first cycle.
    always_comb begin
        state_d    = state_q;
        reg_addr_d = reg_addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        csum_d     = csum_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d    = S_HDR;
                    csum_d     = 8'd0;
                    reg_addr_d = 5'd0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HEADER;
                    busy_d     = 1'b1;
                end
            end

            S_HDR: begin
                if (w_hs) begin
                    state_d    = S_ADDR;
                    tx_valid_d = 1'b0;
                end
            end

            S_ADDR: begin
                shreg_d    = bus.regData;
                tx_data_d  = bus.regData[31:24];
                tx_valid_d = 1'b1;
                cnt_d      = 2'd0;
                state_d    = S_DATA;
            end

            S_DATA: begin
                if (w_hs) begin
                    csum_d    = csum_q ^ shreg_q[31:24];
                    shreg_d   = {shreg_q[23:0], 8'h00};
                    tx_data_d = shreg_q[23:16];
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (reg_addr_q == c_last_addr) begin
                            // Checksum byte must already include the byte just accepted
                            state_d   = S_SUM;
                            tx_data_d = csum_q ^ shreg_q[31:24];
                        end else begin
                            state_d    = S_ADDR;
                            reg_addr_d = reg_addr_q + 5'd1;
                            tx_valid_d = 1'b0;
                        end
                    end
                end
            end

            S_SUM: begin
                if (w_hs) begin
                    state_d    = S_DONE;
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    reg_addr_d = 5'd0;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    assign bus.regAddr  = reg_addr_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sm_reg_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_reg_dump
// Brief    : Self-checking bench for sm_reg_dump (NREGS=3 and NREGS=32 instances)
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_reg_dump;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sm_reg_dump_if bus3 ();
    sm_reg_dump_if bus32 ();

    assign bus3.regData  = 32'h1000_0000 | {27'd0, bus3.regAddr};
    assign bus32.regData = 32'hDEAD_0000 | {27'd0, bus32.regAddr};

    sm_reg_dump #(.NREGS(3),  .HEADER(8'hA5)) dut3  (.clk(clk), .rst(rst), .bus(bus3));
    sm_reg_dump #(.NREGS(32), .HEADER(8'hA5)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    int errors = 0;
    int checks = 0;

    logic [7:0] c_basic [14] = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00,
                                 8'h00, 8'h01, 8'h10, 8'h00, 8'h00, 8'h02, 8'h13};

    // Reference model: position in the expected byte list plus an ADDR gap flag
    bit         m_active [2] = '{1'b0, 1'b0};
    bit         m_gap    [2] = '{1'b0, 1'b0};
    bit         m_donep  [2] = '{1'b0, 1'b0};
    int         m_idx    [2] = '{0, 0};
    logic       prev_v   [2] = '{1'b0, 1'b0};
    logic       prev_r   [2] = '{1'b0, 1'b0};
    logic [7:0] prev_d   [2] = '{8'h00, 8'h00};
    int         done_cnt [2] = '{0, 0};
    logic [7:0] cap3  [$];
    logic [7:0] cap32 [$];
    logic [4:0] addr32 [$];

    function automatic int nregs(int i);
        return (i == 0) ? 3 : 32;
    endfunction

    function automatic logic [31:0] base(int i);
        return (i == 0) ? 32'h1000_0000 : 32'hDEAD_0000;
    endfunction

    function automatic logic [7:0] exp_byte(int i, int k);
        logic [31:0] w;
        logic [7:0]  x;
        if (k == 0) return 8'hA5;
        if (k <= 4 * nregs(i)) begin
            w = base(i) | 32'((k - 1) / 4);
            return 8'(w >> (8 * (3 - ((k - 1) % 4))));
        end
        x = 8'h00;
        for (int j = 1; j <= 4 * nregs(i); j++) x = x ^ exp_byte(i, j);
        return x;
    endfunction

    function automatic logic [4:0] exp_addr(int i);
        int k;
        if (!m_active[i] || m_idx[i] == 0) return 5'd0;
        k = (m_idx[i] - 1) / 4;
        if (k > nregs(i) - 1) k = nregs(i) - 1;
        return 5'(k);
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or item missing (t=%0t)", name, $time);
    endfunction

    function automatic void step(int i, logic st, logic rdy);
        int len;
        len = 4 * nregs(i) + 2;
        if (rst === 1'b1) begin
            m_active[i] = 1'b0;
            m_gap[i]    = 1'b0;
            m_donep[i]  = 1'b0;
            m_idx[i]    = 0;
        end else if (m_donep[i]) begin
            m_donep[i] = 1'b0;
        end else if (!m_active[i]) begin
            if (st === 1'b1) begin
                m_active[i] = 1'b1;
                m_idx[i]    = 0;
                m_gap[i]    = 1'b0;
            end
        end else if (m_gap[i]) begin
            m_gap[i] = 1'b0;
        end else if (rdy === 1'b1) begin
            m_idx[i]++;
            if (m_idx[i] == len) begin
                m_active[i] = 1'b0;
                m_donep[i]  = 1'b1;
            end else if (m_idx[i] <= 4 * nregs(i) && ((m_idx[i] - 1) % 4) == 0) begin
                m_gap[i] = 1'b1;
            end
        end
    endfunction

    function automatic void mon_inst(int i, logic v, logic [7:0] d, logic b, logic dn,
                                     logic [4:0] a, logic rdy, logic st);
        logic exp_v;
        exp_v = m_active[i] && !m_gap[i];
        chk((i == 0) ? "valid3" : "valid32", {31'd0, v}, {31'd0, exp_v});
        if (exp_v) chk((i == 0) ? "data3" : "data32", {24'd0, d}, {24'd0, exp_byte(i, m_idx[i])});
        chk((i == 0) ? "busy3" : "busy32", {31'd0, b}, {31'd0, m_active[i] | m_donep[i]});
        chk((i == 0) ? "done3" : "done32", {31'd0, dn}, {31'd0, m_donep[i]});
        if (!m_donep[i]) chk((i == 0) ? "addr3" : "addr32", {27'd0, a}, {27'd0, exp_addr(i)});
        if (prev_v[i] === 1'b1 && prev_r[i] === 1'b0 && v === 1'b1)
            chk((i == 0) ? "hold3" : "hold32", {24'd0, d}, {24'd0, prev_d[i]});
        if (v === 1'b1 && rdy === 1'b1) begin
            if (i == 0) cap3.push_back(d);
            else begin
                cap32.push_back(d);
                addr32.push_back(a);
            end
        end
        if (dn === 1'b1) done_cnt[i]++;
        prev_v[i] = v;
        prev_r[i] = rdy;
        prev_d[i] = d;
        step(i, st, rdy);
    endfunction

    always @(negedge clk) begin
        mon_inst(0, bus3.tx_valid, bus3.tx_data, bus3.busy, bus3.done, bus3.regAddr,
                 bus3.tx_ready, bus3.start);
        mon_inst(1, bus32.tx_valid, bus32.tx_data, bus32.busy, bus32.done, bus32.regAddr,
                 bus32.tx_ready, bus32.start);
    end

    function automatic void set_start(int i, logic v);
        if (i == 0) bus3.start = v; else bus32.start = v;
    endfunction

    function automatic void set_ready(int i, logic v);
        if (i == 0) bus3.tx_ready = v; else bus32.tx_ready = v;
    endfunction

    function automatic logic get_done(int i);
        return (i == 0) ? bus3.done : bus32.done;
    endfunction

    // Pulse start so it is sampled at edge 0; returns the cycle index of done.
    task automatic run(input int i, input bit rnd, input int limit, output int dc);
        int n;
        @(posedge clk); #1;
        set_start(i, 1'b1);
        if (rnd) set_ready(i, $urandom_range(0, 9) < 3);
        @(posedge clk); #1;
        set_start(i, 1'b0);
        if (rnd) set_ready(i, $urandom_range(0, 9) < 3);
        n  = 0;
        dc = -1;
        while (dc < 0 && n < limit) begin
            @(negedge clk);
            n++;
            if (get_done(i) === 1'b1) dc = n;
            else begin
                @(posedge clk); #1;
                if (rnd) set_ready(i, $urandom_range(0, 9) < 3);
            end
        end
        if (dc < 0) fail_now("done_timeout");
        set_ready(i, 1'b1);
    endtask

    task automatic wait_done3(input int limit);
        int n;
        n = 0;
        while (n < limit && bus3.done !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        if (bus3.done !== 1'b1) fail_now("wait_done3");
    endtask

    task automatic check_stream3(input int mark, input int copies);
        chk("stream3_len", 32'(cap3.size() - mark), 32'(14 * copies));
        for (int c = 0; c < copies; c++)
            for (int j = 0; j < 14; j++)
                if (mark + 14 * c + j < cap3.size())
                    chk("stream3_byte", {24'd0, cap3[mark + 14 * c + j]}, {24'd0, c_basic[j]});
                else
                    fail_now("stream3_byte");
    endtask

    initial begin
        int dc, mark, dmark, hdr, n;
        bit seen;
        bus3.start     = 1'b0;
        bus32.start    = 1'b0;
        bus3.tx_ready  = 1'b0;
        bus32.tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", {31'd0, bus3.tx_valid}, 32'd0);
        chk("rst_data",  {24'd0, bus3.tx_data},  32'd0);
        chk("rst_busy",  {31'd0, bus3.busy},     32'd0);
        chk("rst_done",  {31'd0, bus3.done},     32'd0);
        chk("rst_addr",  {27'd0, bus3.regAddr},  32'd0);

        // Model pins
        chk("pin_csum3",  {24'd0, exp_byte(0, 13)},  32'h13);
        chk("pin_csum32", {24'd0, exp_byte(1, 129)}, 32'h00);

        // Basic dump
        bus3.tx_ready = 1'b1;
        mark = cap3.size();
        run(0, 1'b0, 100, dc);
        chk("basic_done_cycle", 32'(dc), 32'd18);
        check_stream3(mark, 1);

        // Back-pressure
        mark = cap3.size();
        run(0, 1'b1, 500, dc);
        check_stream3(mark, 1);

        // Full-size dump
        bus32.tx_ready = 1'b1;
        mark = cap32.size();
        run(1, 1'b0, 400, dc);
        chk("full_done_cycle", 32'(dc), 32'd163);
        chk("full_len", 32'(cap32.size() - mark), 32'd130);
        if (cap32.size() - mark == 130) begin
            chk("full_hdr",  {24'd0, cap32[mark]},       32'hA5);
            chk("full_b1",   {24'd0, cap32[mark + 1]},   32'hDE);
            chk("full_b2",   {24'd0, cap32[mark + 2]},   32'hAD);
            chk("full_b128", {24'd0, cap32[mark + 128]}, 32'h1F);
            chk("full_csum", {24'd0, cap32[mark + 129]}, 32'h00);
            for (int k = 0; k < 32; k++)
                chk("full_addr_seq", {27'd0, addr32[mark + 1 + 4 * k]}, 32'(k));
        end

        // Start ignored while busy: extra pulses in HDR, DATA and DONE
        mark  = cap3.size();
        dmark = done_cnt[0];
        @(posedge clk); #1 bus3.start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1 bus3.start = (c == 1 || c == 4 || c == 18);
        end
        check_stream3(mark, 1);
        chk("ignored_done_count", 32'(done_cnt[0] - dmark), 32'd1);
        @(negedge clk);
        chk("ignored_idle_busy", {31'd0, bus3.busy}, 32'd0);

        // Start held through DONE relaunches immediately
        mark  = cap3.size();
        dmark = done_cnt[0];
        @(posedge clk); #1 bus3.start = 1'b1;
        @(posedge clk);
        n    = 0;
        hdr  = -1;
        seen = 1'b0;
        while (hdr < 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus3.done === 1'b1) seen = 1'b1;
            else if (seen && bus3.tx_valid === 1'b1) hdr = n;
        end
        @(posedge clk); #1 bus3.start = 1'b0;
        chk("held_hdr_cycle", 32'(hdr), 32'd20);
        wait_done3(100);
        @(posedge clk); #1;
        check_stream3(mark, 2);
        chk("held_done_count", 32'(done_cnt[0] - dmark), 32'd2);

        // Reset during the 2nd DATA byte of register 1 (cycle 9)
        @(posedge clk); #1 bus3.start = 1'b1;
        @(posedge clk); #1 bus3.start = 1'b0;
        repeat (7) @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        dmark = done_cnt[0];
        @(negedge clk);
        chk("midrst_valid", {31'd0, bus3.tx_valid}, 32'd0);
        chk("midrst_busy",  {31'd0, bus3.busy},     32'd0);
        chk("midrst_addr",  {27'd0, bus3.regAddr},  32'd0);
        chk("midrst_done",  {31'd0, bus3.done},     32'd0);
        repeat (5) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt[0] - dmark), 32'd0);
        mark = cap3.size();
        run(0, 1'b0, 100, dc);
        chk("midrst_redump_cycle", 32'(dc), 32'd18);
        check_stream3(mark, 1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
